// File: rtl/hamming_sec_ded_decoder.sv
// -----------------------------------------------------------------------------
// hamming_sec_ded_decoder
//   Program-2 engine. It reads NUM_WORDS 16-bit SECDED codewords from the
//   shared byte-wide data memory and decodes each one. Single-bit errors are
//   corrected, and double-bit errors are flagged. For each codeword it writes
//   an 11-bit data word plus a 2-bit status word back to memory.
//
// Ports
//   clk          rising-edge system clock
//   reset        synchronous, active-high reset (dominant in every state)
//   start        run request level; the run begins when start falls
//   done         high once the run is complete, held until the next start
//   mem_addr     byte address to data memory
//   mem_rd_data  read data, valid the cycle after mem_addr is presented
//   mem_wr_en    write strobe; memory writes mem_wr_data at mem_addr
//   mem_wr_data  write data
//   corr_cnt     single-error words this run (saturating at 15)
//   dbl_cnt      double-error words this run (saturating at 15)
//
// Memory layout is little-endian per word: low byte at base+2i, high byte at
// base+2i+1. Result word = {F[1:0], 3'b000, d11..d1}.
// -----------------------------------------------------------------------------
module hamming_sec_ded_decoder #(
    parameter int unsigned IN_BASE   = 30,
    parameter int unsigned OUT_BASE  = 0,
    parameter int unsigned NUM_WORDS = 15,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic [3:0]        corr_cnt,
    output logic [3:0]        dbl_cnt
);

    localparam int unsigned IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned CW_W   = 16;
    localparam int unsigned DATA_W = 11;

    // DEC sits between CAP_HI and WR_LO so the syndrome tree decodes from
    // registered bytes instead of hanging off the memory read path.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ARMED  = 4'd1,
        S_RD_LO  = 4'd2,
        S_RD_HI  = 4'd3,
        S_CAP_HI = 4'd4,
        S_DEC    = 4'd5,
        S_WR_LO  = 4'd6,
        S_WR_HI  = 4'd7,
        S_DONE   = 4'd8
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [7:0]         lo_q;
    logic [7:0]         hi_q;
    logic [CW_W-1:0]    result_q;
    logic               done_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               mem_wr_en_q;
    logic [7:0]         mem_wr_data_q;
    logic [3:0]         corr_q;
    logic [3:0]         dbl_q;

    // Byte addresses for the current word and for the next word's first read.
    logic [ADDR_W-1:0]  in_hi_addr;
    logic [ADDR_W-1:0]  in_next_addr;
    logic [ADDR_W-1:0]  out_lo_addr;
    logic [ADDR_W-1:0]  out_hi_addr;
    logic [IDX_W-1:0]   idx_next;
    logic               last_word;

    assign idx_next     = idx_q + IDX_W'(1);
    assign last_word    = (idx_q == IDX_W'(NUM_WORDS - 1));
    assign in_hi_addr   = ADDR_W'(IN_BASE)  + ADDR_W'({idx_q, 1'b1});
    assign in_next_addr = ADDR_W'(IN_BASE)  + ADDR_W'({idx_next, 1'b0});
    assign out_lo_addr  = ADDR_W'(OUT_BASE) + ADDR_W'({idx_q, 1'b0});
    assign out_hi_addr  = ADDR_W'(OUT_BASE) + ADDR_W'({idx_q, 1'b1});

    // SECDED decode of the captured codeword.
    logic [CW_W-1:0]   code_c;
    logic [3:0]        syn_c;
    logic              par_c;
    logic [CW_W-1:0]   fixed_c;
    logic [1:0]        flag_c;
    logic [DATA_W-1:0] data_c;
    logic [CW_W-1:0]   dec_result_c;

    assign code_c = {hi_q, lo_q};

    always_comb begin
        syn_c = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (code_c[k]) begin
                syn_c = syn_c ^ 4'(k);
            end
        end
        par_c = ^code_c;

        // Odd overall parity means one flipped bit at position syn_c;
        // syn_c == 0 points at p0, which carries no data.
        fixed_c = code_c;
        if (par_c) begin
            fixed_c[syn_c] = ~code_c[syn_c];
        end

        if (par_c) begin
            flag_c = 2'b01;
        end else if (syn_c != 4'd0) begin
            flag_c = 2'b10;
        end else begin
            flag_c = 2'b00;
        end

        // d11..d5 = bits 15..9, d4..d2 = bits 7..5, d1 = bit 3.
        data_c       = {fixed_c[15:9], fixed_c[7:5], fixed_c[3]};
        dec_result_c = {flag_c, 3'b000, data_c};
    end

    // Sequencer. Outputs are registered on the edge entering each state, so
    // the address belonging to a state is valid throughout that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            lo_q          <= 8'd0;
            hi_q          <= 8'd0;
            result_q      <= '0;
            done_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_data_q <= 8'd0;
            corr_q        <= 4'd0;
            dbl_q         <= 4'd0;
        end else begin
            mem_wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_ARMED;
                    end
                end

                S_ARMED: begin
                    if (!start) begin
                        corr_q     <= 4'd0;
                        dbl_q      <= 4'd0;
                        idx_q      <= '0;
                        mem_addr_q <= ADDR_W'(IN_BASE);
                        state_q    <= S_RD_LO;
                    end
                end

                // Low-byte address is on the bus; queue the high-byte address.
                S_RD_LO: begin
                    mem_addr_q <= in_hi_addr;
                    state_q    <= S_RD_HI;
                end

                S_RD_HI: begin
                    lo_q    <= mem_rd_data;
                    state_q <= S_CAP_HI;
                end

                S_CAP_HI: begin
                    hi_q    <= mem_rd_data;
                    state_q <= S_DEC;
                end

                S_DEC: begin
                    result_q      <= dec_result_c;
                    if (flag_c == 2'b01 && corr_q != 4'hF) begin
                        corr_q <= corr_q + 4'd1;
                    end
                    if (flag_c == 2'b10 && dbl_q != 4'hF) begin
                        dbl_q <= dbl_q + 4'd1;
                    end
                    mem_addr_q    <= out_lo_addr;
                    mem_wr_data_q <= dec_result_c[7:0];
                    mem_wr_en_q   <= 1'b1;
                    state_q       <= S_WR_LO;
                end

                S_WR_LO: begin
                    mem_addr_q    <= out_hi_addr;
                    mem_wr_data_q <= result_q[15:8];
                    mem_wr_en_q   <= 1'b1;
                    state_q       <= S_WR_HI;
                end

                S_WR_HI: begin
                    if (last_word) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q      <= idx_next;
                        mem_addr_q <= in_next_addr;
                        state_q    <= S_RD_LO;
                    end
                end

                S_DONE: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        state_q <= S_ARMED;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done        = done_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_data = mem_wr_data_q;
    assign corr_cnt    = corr_q;
    assign dbl_cnt     = dbl_q;

endmodule
